// File: rtl/regfile_sequencer.sv
// regfile_sequencer: runs one register-file -> ALU -> register-file operation
// per accepted request (read rn/rm, offer operands to the ALU, wait for the
// result, optionally write it back to rd). Every output is a register.
// Optional feature macro: REGSEQ_IMM_OPERAND_EN adds an immediate that can
// replace the second register operand.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// READ  | rf_a1/rf_a2 presented to the register file
// CAPT  | read data returned, captured into alu_a/alu_b
// ISSUE | alu_valid=1 until alu_ready
// WAIT  | handshake done, waiting for alu_result_valid
// WRITE | one cycle: optional write-back and done pulse
module regfile_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_rn,
  input  logic [3:0]  req_rm,
  input  logic [3:0]  req_rd,
  input  logic        req_wb,
`ifdef REGSEQ_IMM_OPERAND_EN
  input  logic        req_use_imm,
  input  logic [31:0] req_imm,
`endif
  output logic [3:0]  rf_a1,
  output logic [3:0]  rf_a2,
  output logic [3:0]  rf_a3,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  output logic [31:0] rf_wd3,
  output logic        rf_we3,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_valid,
  input  logic        alu_ready,
  input  logic [31:0] alu_result,
  input  logic        alu_result_valid,
  output logic        done,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPT, S_ISSUE, S_WAIT, S_WRITE
  } state_t;

  // Counter is 5 bits wide, so the limit is truncated to that width.
  localparam logic [4:0] TIMEOUT_CNT = 5'(TIMEOUT_CYCLES);

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt, cnt_inc;
  logic        accept, capture, latch_result;
  logic        err_nxt;
  logic [3:0]  rd_q;
  logic        wb_q;
`ifdef REGSEQ_IMM_OPERAND_EN
  logic        use_imm_q;
  logic [31:0] imm_q;
`endif

  assign cnt_inc = cnt + 5'd1;

  // State and timeout counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; completion takes priority over timeout in the same cycle.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    accept       = 1'b0;
    capture      = 1'b0;
    latch_result = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = S_READ;
        end
      end
      S_READ: state_nxt = S_CAPT;
      S_CAPT: begin
        capture   = 1'b1;
        cnt_nxt   = 5'd0;
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (alu_ready && alu_result_valid) begin
          latch_result = 1'b1;
          state_nxt    = S_WRITE;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt_inc;
          if (alu_ready) state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (alu_result_valid) begin
          latch_result = 1'b1;
          state_nxt    = S_WRITE;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered status/strobe outputs, derived from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      busy      <= 1'b0;
      alu_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rf_we3    <= 1'b0;
    end else begin
      req_ready <= (state_nxt == S_IDLE);
      busy      <= (state_nxt != S_IDLE);
      alu_valid <= (state_nxt == S_ISSUE);
      done      <= (state_nxt == S_WRITE);
      err       <= err_nxt;
      rf_we3    <= (state_nxt == S_WRITE) && wb_q;
    end
  end

  // Request fields, operand capture and result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_a1     <= 4'd0;
      rf_a2     <= 4'd0;
      rf_a3     <= 4'd0;
      rf_wd3    <= 32'd0;
      alu_a     <= 32'd0;
      alu_b     <= 32'd0;
      rd_q      <= 4'd0;
      wb_q      <= 1'b0;
`ifdef REGSEQ_IMM_OPERAND_EN
      use_imm_q <= 1'b0;
      imm_q     <= 32'd0;
`endif
    end else begin
      if (accept) begin
        rf_a1     <= req_rn;
        rf_a2     <= req_rm;
        rd_q      <= req_rd;
        wb_q      <= req_wb;
`ifdef REGSEQ_IMM_OPERAND_EN
        use_imm_q <= req_use_imm;
        imm_q     <= req_imm;
`endif
      end
      if (capture) begin
        alu_a <= rf_rd1;
`ifdef REGSEQ_IMM_OPERAND_EN
        alu_b <= use_imm_q ? imm_q : rf_rd2;
`else
        alu_b <= rf_rd2;
`endif
      end
      if (latch_result) begin
        rf_a3  <= rd_q;
        rf_wd3 <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: an external register file and ALU are modelled
// around the DUT; a driver issues requests and plays the ALU, a monitor pops
// expected outcomes from a queue on every done/err pulse.
module tb_regfile_sequencer;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [3:0]  req_rn = '0, req_rm = '0, req_rd = '0;
  logic        req_wb = 1'b0;
`ifdef REGSEQ_IMM_OPERAND_EN
  logic        req_use_imm = 1'b0;
  logic [31:0] req_imm = '0;
  bit          force_imm = 1'b0;
`endif
  logic [3:0]  rf_a1, rf_a2, rf_a3;
  logic [31:0] rf_rd1, rf_rd2, rf_wd3;
  logic        rf_we3;
  logic [31:0] alu_a, alu_b;
  logic        alu_valid;
  logic        alu_ready = 1'b0;
  logic [31:0] alu_result = '0;
  logic        alu_result_valid = 1'b0;
  logic        done, err, busy;

  regfile_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rn(req_rn), .req_rm(req_rm), .req_rd(req_rd), .req_wb(req_wb),
`ifdef REGSEQ_IMM_OPERAND_EN
    .req_use_imm(req_use_imm), .req_imm(req_imm),
`endif
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .rf_wd3(rf_wd3), .rf_we3(rf_we3),
    .alu_a(alu_a), .alu_b(alu_b), .alu_valid(alu_valid),
    .alu_ready(alu_ready), .alu_result(alu_result),
    .alu_result_valid(alu_result_valid),
    .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External register file: synchronous read, negedge write.
  logic [31:0] rf [16];
  always @(posedge clk) begin
    rf_rd1 <= rf[rf_a1];
    rf_rd2 <= rf[rf_a2];
  end
  always @(negedge clk) if (rf_we3) rf[rf_a3] <= rf_wd3;

  // Reference register contents, updated whenever a request is issued.
  logic [31:0] refm [16];

  typedef struct {
    bit          is_err;
    bit          wb;
    logic [3:0]  rd;
    logic [31:0] a, b, wd;
    int          acc;
    int          extra;
  } exp_t;
  exp_t q[$];

  int total = 0, bad = 0;
  int next_ok = -1;
  bit gap_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on done/err.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      check("busy_vs_ready", 32'(busy), 32'(!req_ready));
      if (!done) check("we_outside_write", 32'(rf_we3), 32'd0);
      if (alu_valid && q.size() > 0) begin
        check("alu_a", alu_a, q[0].a);
        check("alu_b", alu_b, q[0].b);
      end
      if (done || err) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_end: done=%0b err=%0b with nothing outstanding", done, err);
        end else begin
          e = q.pop_front();
          check("err_pulse", 32'(err), 32'(e.is_err));
          check("done_pulse", 32'(done), 32'(!e.is_err));
          if (!e.is_err) begin
            check("we3", 32'(rf_we3), 32'(e.wb));
            if (e.wb) begin
              check("a3", 32'(rf_a3), 32'(e.rd));
              check("wd3", rf_wd3, e.wd);
            end
            check("done_latency", cyc, e.acc + 3 + e.extra);
            next_ok = cyc + 2;
          end else begin
            check("err_no_write", 32'(rf_we3), 32'd0);
            check("err_alu_valid", 32'(alu_valid), 32'd0);
            check("err_latency", cyc, e.acc + 2 + TO);
            next_ok = cyc + 1;
          end
        end
      end
    end
  end

  // One request plus ALU behaviour: alu_ready rises dr cycles into ISSUE, the
  // result follows dres cycles after that (never => no result). rst_at >= 0
  // pulls reset at that ALU cycle.  Entered and left on a negedge.
  task automatic run_txn(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                         input logic wb, input int dr, input int dres, input bit never,
                         input int rst_at);
    exp_t e;
    int w;
    bit gap;
    logic [31:0] opa, opb;
    gap = gap_ok;
    gap_ok = 1'b0;
    req_rn = rn; req_rm = rm; req_rd = rd; req_wb = wb;
`ifdef REGSEQ_IMM_OPERAND_EN
    req_use_imm = force_imm ? 1'b1 : ($urandom_range(0, 3) == 0);
    req_imm     = force_imm ? 32'h100 : $urandom;
`endif
    req_valid = 1'b1;
    w = 0;
    while (req_ready !== 1'b1 && w < 64) begin @(negedge clk); w++; end
    if (req_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL accept_wait: req_ready low for %0d cycles", w);
      req_valid = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    if (gap) check("accept_edge", e.acc, next_ok);
    e.is_err = never || (dr + dres >= TO);
    e.wb = wb;
    e.rd = rd;
    e.a  = refm[rn];
`ifdef REGSEQ_IMM_OPERAND_EN
    e.b  = req_use_imm ? req_imm : refm[rm];
`else
    e.b  = refm[rm];
`endif
    e.wd = e.a + e.b;
    e.extra = dr + dres;
    if (!e.is_err && wb && rst_at < 0) refm[rd] = e.wd;
    q.push_back(e);
    @(posedge clk); #1 req_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (!alu_valid && w < 8) begin @(negedge clk); w++; end
    if (!alu_valid) begin
      total++; bad++;
      $display("FAIL issue_wait: alu_valid low for %0d cycles", w);
      return;
    end
    opa = '0; opb = '0;
    for (int k = 0; k <= TO + 2; k++) begin
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_we3", 32'(rf_we3), 32'd0);
        check("rst_alu_valid", 32'(alu_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_a1", 32'(rf_a1), 32'd0);
        q.delete();
        alu_ready = 1'b0; alu_result_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);
        return;
      end
      alu_ready = (k == dr);
      if (k == dr) begin opa = alu_a; opb = alu_b; end
      alu_result = opa + opb;
      alu_result_valid = !never && (k == dr + dres);
      if (alu_result_valid) break;
      @(negedge clk);
    end
    @(negedge clk);
    alu_ready = 1'b0; alu_result_valid = 1'b0;
    gap_ok = !e.is_err;
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      if (i == 2) v = 32'd5;
      if (i == 3) v = 32'd7;
      rf[i] <= v;
      refm[i] = v;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_we3", 32'(rf_we3), 32'd0);
    check("reset_alu_valid", 32'(alu_valid), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_a3", 32'(rf_a3), 32'd0);
    check("reset_wd3", rf_wd3, 32'd0);
    check("reset_alu_b", alu_b, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_out_of_reset", 32'(req_ready), 32'd1);

    run_txn(4'd2, 4'd3, 4'd4, 1'b1, 0, 0, 1'b0, -1);   // 5+7 -> R4, minimum latency
    run_txn(4'd2, 4'd3, 4'd4, 1'b0, 0, 0, 1'b0, -1);   // no write-back
    run_txn(4'd2, 4'd3, 4'd5, 1'b1, 3, 2, 1'b0, -1);   // ready late, result late
    run_txn(4'd4, 4'd4, 4'd4, 1'b1, 0, 1, 1'b0, -1);   // rn==rm==rd
    run_txn(4'd2, 4'd3, 4'd6, 1'b1, 0, 0, 1'b1, -1);   // no result: timeout
    run_txn(4'd1, 4'd2, 4'd7, 1'b1, 5, 10, 1'b0, -1);  // last cycle before timeout
    run_txn(4'd1, 4'd2, 4'd8, 1'b1, 6, 10, 1'b0, -1);  // result one cycle too late
    run_txn(4'd2, 4'd3, 4'd9, 1'b1, 0, 10, 1'b0, 3);   // reset while in WAIT
    run_txn(4'd4, 4'd5, 4'd10, 1'b1, 0, 0, 1'b0, -1);
    run_txn(4'd10, 4'd2, 4'd11, 1'b1, 0, 0, 1'b0, -1);
`ifdef REGSEQ_IMM_OPERAND_EN
    force_imm = 1'b1;
    run_txn(4'd2, 4'd3, 4'd12, 1'b1, 0, 0, 1'b0, -1);  // imm replaces R3
    force_imm = 1'b0;
`endif
    for (int n = 0; n < 40; n++) begin
      run_txn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 4),
              ($urandom_range(0, 9) == 0), -1);
    end
    repeat (4) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    for (int i = 0; i < 16; i++) check($sformatf("rf_final_r%0d", i), rf[i], refm[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
